// File: rtl/lfsr_pn_if.sv
// lfsr_pn_if: control and status bundle for the lfsr_pn pattern generator.
// The master side issues advance/load requests, the slave side is the LFSR.
interface lfsr_pn_if #(
    parameter int unsigned W = 8
);
    logic         enb;
    logic         load;
    logic [W-1:0] seed_i;
    logic [W-1:0] q;
    logic [W-1:0] cnt;
    logic         wrap;
    logic         err;

    modport master (output enb, load, seed_i, input q, cnt, wrap, err);
    modport slave  (input enb, load, seed_i, output q, cnt, wrap, err);
endinterface

// File: rtl/lfsr_pn.sv
// lfsr_pn: parametrised maximal-length Fibonacci LFSR (shift toward MSB).
// Advances STEPS shifts per enabled cycle, supports runtime seed load,
// zero-state recovery, and a period counter with a one-cycle wrap pulse.
module lfsr_pn #(
    parameter int unsigned  W     = 8,
    parameter int unsigned  STEPS = 1,
    parameter logic [W-1:0] SEED  = W'(1)
) (
    input  logic     clk,
    input  logic     rst,
    lfsr_pn_if.slave bus
);

    if (W < 3 || W > 32) begin : g_bad_w
        $error("lfsr_pn: W must be in 3..32");
    end
    if (STEPS < 1 || STEPS > W) begin : g_bad_steps
        $error("lfsr_pn: STEPS must be in 1..W");
    end

    // Single-bit mask for 1-indexed tap n (tap W is the MSB).
    function automatic logic [31:0] tap(input int unsigned n);
        return 32'(1) << (n - 1);
    endfunction

    // Maximal-length tap sets for every supported width.
    function automatic logic [31:0] tap_mask(input int unsigned w);
        case (w)
            3:       return tap(3)  | tap(2);
            4:       return tap(4)  | tap(3);
            5:       return tap(5)  | tap(3);
            6:       return tap(6)  | tap(5);
            7:       return tap(7)  | tap(6);
            8:       return tap(8)  | tap(6)  | tap(5)  | tap(4);
            9:       return tap(9)  | tap(5);
            10:      return tap(10) | tap(7);
            11:      return tap(11) | tap(9);
            12:      return tap(12) | tap(6)  | tap(4)  | tap(1);
            13:      return tap(13) | tap(4)  | tap(3)  | tap(1);
            14:      return tap(14) | tap(5)  | tap(3)  | tap(1);
            15:      return tap(15) | tap(14);
            16:      return tap(16) | tap(15) | tap(13) | tap(4);
            17:      return tap(17) | tap(14);
            18:      return tap(18) | tap(11);
            19:      return tap(19) | tap(6)  | tap(2)  | tap(1);
            20:      return tap(20) | tap(17);
            21:      return tap(21) | tap(19);
            22:      return tap(22) | tap(21);
            23:      return tap(23) | tap(18);
            24:      return tap(24) | tap(23) | tap(22) | tap(17);
            25:      return tap(25) | tap(22);
            26:      return tap(26) | tap(6)  | tap(2)  | tap(1);
            27:      return tap(27) | tap(5)  | tap(2)  | tap(1);
            28:      return tap(28) | tap(25);
            29:      return tap(29) | tap(27);
            30:      return tap(30) | tap(6)  | tap(4)  | tap(1);
            31:      return tap(31) | tap(28);
            32:      return tap(32) | tap(22) | tap(2)  | tap(1);
            default: return '0;
        endcase
    endfunction

    localparam logic [W-1:0] MASK     = W'(tap_mask(W));
    // A zero seed would lock the register, so it is promoted to 1.
    localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;

    function automatic logic [W-1:0] shift1(input logic [W-1:0] s);
        return {s[W-2:0], ^(s & MASK)};
    endfunction

    logic [W-1:0] q_r;
    logic [W-1:0] start_r;
    logic [W-1:0] cnt_r;
    logic [W-1:0] nxt;
    logic         wrap_r;
    logic         err_r;

    // Compose the single-shift function STEPS times within one cycle.
    always_comb begin
        nxt = q_r;
        for (int unsigned i = 0; i < STEPS; i++) begin
            nxt = shift1(nxt);
        end
    end

    // State update: load beats zero-recovery beats enable; pulses default low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r     <= SEED_EFF;
            start_r <= SEED_EFF;
            cnt_r   <= '0;
            wrap_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            wrap_r <= 1'b0;
            err_r  <= 1'b0;
            if (bus.load) begin
                if (bus.seed_i == '0) begin
                    q_r     <= W'(1);
                    start_r <= W'(1);
                    err_r   <= 1'b1;
                end else begin
                    q_r     <= bus.seed_i;
                    start_r <= bus.seed_i;
                end
                cnt_r <= '0;
            end else if (q_r == '0) begin
                q_r   <= W'(1);
                err_r <= 1'b1;
            end else if (bus.enb) begin
                q_r <= nxt;
                if (nxt == start_r) begin
                    wrap_r <= 1'b1;
                    cnt_r  <= '0;
                end else begin
                    cnt_r <= cnt_r + W'(1);
                end
            end
        end
    end

    assign bus.q    = q_r;
    assign bus.cnt  = cnt_r;
    assign bus.wrap = wrap_r;
    assign bus.err  = err_r;

endmodule

// File: tb/tb_lfsr_pn.sv
// tb_lfsr_pn: self-checking bench for lfsr_pn with an integer-arithmetic
// reference model, literal anchors, and period sweeps for several widths.
module tb_lfsr_pn;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int unsigned total = 0;
    int unsigned bad = 0;

    always #5 clk = ~clk;

    lfsr_pn_if #(.W(8))  ia  ();
    lfsr_pn_if #(.W(8))  ib  ();
    lfsr_pn_if #(.W(3))  i3  ();
    lfsr_pn_if #(.W(4))  i4  ();
    lfsr_pn_if #(.W(5))  i5  ();
    lfsr_pn_if #(.W(16)) i16 ();

    lfsr_pn #(.W(8), .STEPS(1), .SEED(8'h01)) dut   (.clk(clk), .rst(rst_a), .bus(ia));
    lfsr_pn #(.W(8), .STEPS(3), .SEED(8'h01)) dut3  (.clk(clk), .rst(rst_b), .bus(ib));
    lfsr_pn #(.W(3))                          dw3   (.clk(clk), .rst(rst_b), .bus(i3));
    lfsr_pn #(.W(4))                          dw4   (.clk(clk), .rst(rst_b), .bus(i4));
    lfsr_pn #(.W(5))                          dw5   (.clk(clk), .rst(rst_b), .bus(i5));
    lfsr_pn #(.W(16))                         dw16  (.clk(clk), .rst(rst_b), .bus(i16));

    // Taps 8,6,5,4 as a bit set; feedback is the parity of the tapped bits.
    localparam int unsigned TAP8 = (1 << (8 - 1)) | (1 << (6 - 1)) | (1 << (5 - 1)) | (1 << (4 - 1));

    function automatic logic [7:0] adv8(input logic [7:0] v, input int unsigned n);
        int unsigned x;
        x = 32'(v);
        for (int unsigned k = 0; k < n; k++) begin
            x = ((x * 2) + ($countones(x & TAP8) % 2)) % 256;
        end
        return 8'(x);
    endfunction

    // Reference model for the main W=8, STEPS=1 instance.
    logic [7:0] m_q, m_st, m_cnt;
    logic       m_wrap, m_err;
    logic       inj_zero = 1'b0;

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            m_q <= 8'h01; m_st <= 8'h01; m_cnt <= 8'h00; m_wrap <= 1'b0; m_err <= 1'b0;
        end else if (ia.load) begin
            m_q    <= (ia.seed_i == 8'h00) ? 8'h01 : ia.seed_i;
            m_st   <= (ia.seed_i == 8'h00) ? 8'h01 : ia.seed_i;
            m_cnt  <= 8'h00;
            m_err  <= (ia.seed_i == 8'h00);
            m_wrap <= 1'b0;
        end else if (inj_zero || m_q == 8'h00) begin
            m_q <= 8'h01; m_err <= 1'b1; m_wrap <= 1'b0;
        end else if (ia.enb) begin
            m_q    <= adv8(m_q, 1);
            m_wrap <= (adv8(m_q, 1) == m_st);
            m_cnt  <= (adv8(m_q, 1) == m_st) ? 8'h00 : 8'(m_cnt + 8'h01);
            m_err  <= 1'b0;
        end else begin
            m_wrap <= 1'b0; m_err <= 1'b0;
        end
    end

    // Reference model for the STEPS=3 instance (never loaded, start stays 1).
    logic [7:0] n_q, n_cnt;
    logic       n_wrap;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            n_q <= 8'h01; n_cnt <= 8'h00; n_wrap <= 1'b0;
        end else if (ib.enb) begin
            n_q    <= adv8(n_q, 3);
            n_wrap <= (adv8(n_q, 3) == 8'h01);
            n_cnt  <= (adv8(n_q, 3) == 8'h01) ? 8'h00 : 8'(n_cnt + 8'h01);
        end else begin
            n_wrap <= 1'b0;
        end
    end

    logic        run_b = 1'b0;
    logic        done16 = 1'b0;
    int unsigned ticks_b = 0;
    int unsigned s3n = 0;
    int unsigned s3_wraps = 0;
    int unsigned sw_n [4] = '{0, 0, 0, 0};
    int unsigned sw_wraps [4] = '{0, 0, 0, 0};
    int unsigned sw_per [4] = '{7, 15, 31, 65535};
    bit          seen [256];
    logic [7:0]  exp_seq [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance one clock, then compare every instance against its expectation.
    task automatic tick();
        logic        ww [4];
        logic [31:0] wq [4];
        @(negedge clk);
        chk("q",      64'(ia.q), inj_zero ? 64'h0 : 64'(m_q));
        chk("cnt",    64'(ia.cnt), 64'(m_cnt));
        chk("wrap",   64'(ia.wrap), 64'(m_wrap));
        chk("err",    64'(ia.err), 64'(m_err));
        chk("s3_q",   64'(ib.q), 64'(n_q));
        chk("s3_cnt", 64'(ib.cnt), 64'(n_cnt));
        chk("s3_wrap", 64'(ib.wrap), 64'(n_wrap));
        chk("s3_err", 64'(ib.err), 64'h0);
        if (run_b) begin
            ticks_b++;
            s3n++;
            if (ib.wrap) begin
                chk("s3_period", 64'(s3n), 64'd85);
                s3n = 0;
                s3_wraps++;
            end
            ww[0] = i3.wrap;  wq[0] = 32'(i3.q);
            ww[1] = i4.wrap;  wq[1] = 32'(i4.q);
            ww[2] = i5.wrap;  wq[2] = 32'(i5.q);
            ww[3] = i16.wrap; wq[3] = 32'(i16.q);
            for (int k = 0; k < 4; k++) begin
                sw_n[k]++;
                if (ww[k]) begin
                    chk($sformatf("period_%0d", k), 64'(sw_n[k]), 64'(sw_per[k]));
                    chk($sformatf("wrap_q_%0d", k), 64'(wq[k]), 64'h1);
                    sw_n[k] = 0;
                    sw_wraps[k]++;
                    if (k == 3) done16 = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int unsigned n;
        int unsigned first_w;
        logic        got;

        ia.enb = 1'b0; ia.load = 1'b0; ia.seed_i = '0;
        ib.enb = 1'b0; ib.load = 1'b0; ib.seed_i = '0;
        i3.enb = 1'b0; i3.load = 1'b0; i3.seed_i = '0;
        i4.enb = 1'b0; i4.load = 1'b0; i4.seed_i = '0;
        i5.enb = 1'b0; i5.load = 1'b0; i5.seed_i = '0;
        i16.enb = 1'b0; i16.load = 1'b0; i16.seed_i = '0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;

        tick(); tick();
        chk("rst_q",    64'(ia.q), 64'h01);
        chk("rst_cnt",  64'(ia.cnt), 64'h0);
        chk("rst_wrap", 64'(ia.wrap), 64'h0);
        chk("rst_err",  64'(ia.err), 64'h0);
        chk("rst_s3_q", 64'(ib.q), 64'h01);

        // Release and run one full period on the main instance.
        rst_a = 1'b1; rst_b = 1'b1; run_b = 1'b1;
        ia.enb = 1'b1; ib.enb = 1'b1;
        i3.enb = 1'b1; i4.enb = 1'b1; i5.enb = 1'b1; i16.enb = 1'b1;
        seen[1] = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (i <= 6) chk("seq", 64'(ia.q), 64'(exp_seq[i]));
            if (i == 1) chk("s3_first", 64'(ib.q), 64'h08);
            if (i == 2) chk("s3_second", 64'(ib.q), 64'h47);
            if (i < 255) begin
                chk("cnt_lin", 64'(ia.cnt), 64'(i));
                chk("unique", 64'(seen[ia.q]), 64'h0);
                seen[ia.q] = 1'b1;
            end else begin
                chk("wrap_q",     64'(ia.q), 64'h01);
                chk("wrap_pulse", 64'(ia.wrap), 64'h1);
                chk("wrap_cnt",   64'(ia.cnt), 64'h0);
            end
        end

        // Load beats enable; the next wrap is relative to the loaded seed.
        ia.load = 1'b1; ia.seed_i = 8'hA5; ia.enb = 1'b1;
        tick();
        chk("load_q",   64'(ia.q), 64'hA5);
        chk("load_cnt", 64'(ia.cnt), 64'h0);
        ia.load = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 300) begin
            tick();
            n++;
            if (ia.wrap) got = 1'b1;
        end
        chk("a5_wrap_seen", 64'(got), 64'h1);
        chk("a5_period",    64'(n), 64'd255);
        chk("a5_wrap_q",    64'(ia.q), 64'hA5);

        // Zero seed promotes to 1 and flags err for one cycle.
        ia.load = 1'b1; ia.seed_i = 8'h00; ia.enb = 1'b1;
        tick();
        chk("load0_q",   64'(ia.q), 64'h01);
        chk("load0_err", 64'(ia.err), 64'h1);
        chk("load0_cnt", 64'(ia.cnt), 64'h0);
        ia.load = 1'b0; ia.enb = 1'b0;
        tick();
        chk("err_once", 64'(ia.err), 64'h0);
        chk("hold_q",   64'(ia.q), 64'h01);
        ia.enb = 1'b1;
        repeat (5) tick();
        ia.enb = 1'b0;
        tick();
        chk("hold_q5",   64'(ia.q), 64'h23);
        chk("hold_cnt5", 64'(ia.cnt), 64'd5);

        // Corrupt the state to zero between edges; expect recovery next edge.
        #7;
        force dut.q_r = 8'h00;
        inj_zero = 1'b1;
        #1;
        release dut.q_r;
        tick();
        ia.enb = 1'b1;
        @(posedge clk);
        #1 inj_zero = 1'b0;
        tick();
        chk("recov_q",   64'(ia.q), 64'h01);
        chk("recov_err", 64'(ia.err), 64'h1);
        chk("recov_cnt", 64'(ia.cnt), 64'd5);
        ia.enb = 1'b0;
        tick();
        chk("recov_err_once", 64'(ia.err), 64'h0);

        // Randomised mix of enables, loads and zero seeds.
        repeat (400) begin
            ia.enb    = 1'($urandom_range(0, 1));
            ia.load   = ($urandom_range(0, 19) == 0);
            ia.seed_i = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            tick();
        end

        // Asynchronous reset mid-run, checked before the next clock edge.
        ia.load = 1'b1; ia.seed_i = 8'h5A; ia.enb = 1'b0;
        tick();
        ia.load = 1'b0; ia.enb = 1'b1;
        repeat (3) tick();
        ia.enb = 1'b0;
        #2 rst_a = 1'b0;
        #1;
        chk("async_q",    64'(ia.q), 64'h01);
        chk("async_cnt",  64'(ia.cnt), 64'h0);
        chk("async_wrap", 64'(ia.wrap), 64'h0);
        tick();
        rst_a = 1'b1; ia.enb = 1'b1;

        // Loaded seed is forgotten: period again ends at 0x01. Also finishes W=16 sweep.
        n = 0; first_w = 0;
        while (!done16 && n < 70000) begin
            tick();
            n++;
            if (ia.wrap && first_w == 0) begin
                first_w = n;
                chk("post_rst_period", 64'(n), 64'd255);
                chk("post_rst_wrap_q", 64'(ia.q), 64'h01);
            end
        end
        chk("post_rst_wrap_seen", 64'(first_w != 0), 64'h1);
        chk("w16_done", 64'(done16), 64'h1);
        chk("w3_wraps",  64'(sw_wraps[0]), 64'(ticks_b / 7));
        chk("w4_wraps",  64'(sw_wraps[1]), 64'(ticks_b / 15));
        chk("w5_wraps",  64'(sw_wraps[2]), 64'(ticks_b / 31));
        chk("s3_wraps",  64'(s3_wraps), 64'(ticks_b / 85));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
